// File: rtl/median_filter_pkg.sv
// ---------------------------------------------------------------------------
// median_filter_pkg
//   Shared definitions for the NxN median datapath.
//   - state_t       : line-buffer front-end FSM states (FILL, RUN)
//   - cnt_width()   : bit width needed for a 0..n-1 counter / index
//   - col_elem_lsb(): LSB position of element j in an N-element column word.
//                     Element 0 (oldest row) sits in the most significant
//                     slot, element N-1 (current pixel) in the least.
// ---------------------------------------------------------------------------
package median_filter_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned col_elem_lsb(input int unsigned n,
                                                 input int unsigned j,
                                                 input int unsigned dw);
        return (n - 1 - j) * dw;
    endfunction

endpackage

// File: rtl/median_line_delay.sv
// ---------------------------------------------------------------------------
// median_line_delay
//   One image line of delay: a DEPTH-entry, DATA_WIDTH-wide memory indexed
//   by the current column. The stored value for addr is presented on dout
//   combinationally; when en is high the new value overwrites it at the
//   clock edge (read-before-write). Contents are intentionally not reset.
//
//   Ports
//     clk   in   clock, rising edge
//     en    in   write enable (pixel accepted this cycle)
//     addr  in   column index 0..DEPTH-1
//     din   in   value to store at addr
//     dout  out  value stored at addr one line ago
// ---------------------------------------------------------------------------
module median_line_delay
    import median_filter_pkg::*;
#(
    parameter int DEPTH      = 640,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/median_line_buffer.sv
// ---------------------------------------------------------------------------
// median_line_buffer
//   Streaming window front-end for the NxN median filter. Buffers N-1 image
//   lines and, for each accepted raster-order pixel, emits the vertical
//   column of N pixels ending at that pixel.
//
//   Handshake: a transfer happens on an interface when valid && ready are
//   both high at a rising clock edge; valid never depends on ready, and the
//   output word is held stable while out_valid && !out_ready.
//
//   Ports
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   input pixel valid
//     in_data    in   input pixel (DATA_WIDTH)
//     in_ready   out  pixel accepted this cycle when in_valid is high
//     out_valid  out  column valid
//     out_data   out  column (N*DATA_WIDTH); element j at
//                     [(N-j)*DATA_WIDTH-1 -: DATA_WIDTH], j=0 oldest row
//     out_ready  in   downstream accepts column
//     out_last   out  column belongs to the frame's final pixel
//
//   Build option MEDIAN_LINE_BUF_TOP_REPLICATE_EN: when defined, the first
//   N-1 rows of each frame also emit columns, with rows above the image
//   replaced by the row-0 pixel of the same column.
// ---------------------------------------------------------------------------
module median_line_buffer
    import median_filter_pkg::*;
#(
    parameter int N          = 5,
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [N*DATA_WIDTH-1:0] out_data,
    input  logic                    out_ready,
    output logic                    out_last
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(N - 2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    state_t        state;

    logic accept;
    logic end_of_line;
    logic end_of_frame;
    logic emit;

    // line_d[k] feeds delay line k, line_q[k] is its output (row - 1 - k)
    logic [DATA_WIDTH-1:0] line_d [N-1];
    logic [DATA_WIDTH-1:0] line_q [N-1];

    logic [N*DATA_WIDTH-1:0] col_next;

    // A new column can always be taken once the output register is free
    // or is being drained in the same cycle.
    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign end_of_line  = (col == COL_LAST);
    assign end_of_frame = end_of_line && (row == ROW_LAST);

    // ---------------------------------------------------------------------
    // Chained delay lines: line 0 stores the incoming pixel, line k+1
    // stores the value line k is giving up at this column.
    // ---------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < N - 1; k++) begin : g_line
            if (k == 0) begin : g_head
                assign line_d[k] = in_data;
            end else begin : g_chain
                assign line_d[k] = line_q[k-1];
            end

            median_line_delay #(
                .DEPTH      (IMG_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (CW)
            ) u_line (
                .clk  (clk),
                .en   (accept),
                .addr (col),
                .din  (line_d[k]),
                .dout (line_q[k])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Column assembly: element j comes from line N-2-j, the last element
    // is the current pixel.
    // ---------------------------------------------------------------------
`ifdef MEDIAN_LINE_BUF_TOP_REPLICATE_EN
    logic [DATA_WIDTH-1:0] row0_pix;

    // Row-0 pixel of the current column: the incoming pixel itself on
    // row 0, otherwise whichever delay line is exactly 'row' lines back.
    always_comb begin
        row0_pix = in_data;
        for (int i = 0; i < N - 1; i++) begin
            if (int'(row) == i + 1) begin
                row0_pix = line_q[i];
            end
        end
    end
`endif

    always_comb begin
        col_next = '0;
        for (int j = 0; j < N - 1; j++) begin
            col_next[col_elem_lsb(N, j, DATA_WIDTH) +: DATA_WIDTH] = line_q[N-2-j];
        end
        col_next[col_elem_lsb(N, N - 1, DATA_WIDTH) +: DATA_WIDTH] = in_data;
`ifdef MEDIAN_LINE_BUF_TOP_REPLICATE_EN
        // Element j would come from row (row - (N-1-j)); above the image
        // that line still holds the previous frame, so use row 0 instead.
        for (int j = 0; j < N - 1; j++) begin
            if (int'(row) < N - 1 - j) begin
                col_next[col_elem_lsb(N, j, DATA_WIDTH) +: DATA_WIDTH] = row0_pix;
            end
        end
`endif
    end

`ifdef MEDIAN_LINE_BUF_TOP_REPLICATE_EN
    assign emit = 1'b1;
`else
    assign emit = (state == RUN);
`endif

    // ---------------------------------------------------------------------
    // Counters, FSM and output register.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            state     <= FILL;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                col <= end_of_line ? '0 : col + 1'b1;
                if (end_of_line) begin
                    row <= end_of_frame ? '0 : row + 1'b1;
                end

                case (state)
                    FILL: if (end_of_line && (row == ROW_FILL_LAST)) state <= RUN;
                    RUN:  if (end_of_frame) state <= FILL;
                    default: state <= FILL;
                endcase
            end

            if (accept && emit) begin
                out_valid <= 1'b1;
                out_data  <= col_next;
                out_last  <= end_of_frame;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_median_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_median_line_buffer
//   Bench for median_line_buffer with N=3, DATA_WIDTH=8, 4x4 frames.
//   The reference model keeps the pixels of the current frame in a 2-D
//   array and builds each expected column directly from image rows.
//   Build with +define+MEDIAN_LINE_BUF_TOP_REPLICATE_EN to check the
//   replicate variant.
// ---------------------------------------------------------------------------
module tb_median_line_buffer;

    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int CWID = N * DW;

`ifdef MEDIAN_LINE_BUF_TOP_REPLICATE_EN
    localparam bit REP        = 1'b1;
    localparam int FRAME_OUTS = IW * IH;
`else
    localparam bit REP        = 1'b0;
    localparam int FRAME_OUTS = (IH - N + 1) * IW;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            out_valid;
    logic [CWID-1:0] out_data;
    logic            out_ready;
    logic            out_last;

    always #5 clk = ~clk;

    median_line_buffer #(
        .N          (N),
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    // ---------------- scoreboard state ----------------
    logic [CWID:0]   exp_q[$];       // {last, column}
    int              n_checks = 0;
    int              n_errors = 0;
    logic [DW-1:0]   img [IH][IW];
    int              mr = 0;
    int              mc = 0;
    int              acc_cnt = 0;
    int              seen_lasts = 0;
    int              out_cnt = 0;
    logic            prev_stall = 1'b0;
    logic [CWID-1:0] prev_data = '0;
    logic            prev_last = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: record the pixel in the frame image, build the
    // column from image rows above it, advance the raster position.
    task automatic model_accept(input logic [DW-1:0] d);
        int              src;
        logic [CWID-1:0] e;
        logic            last;
        img[mr][mc] = d;
        if (REP || mr >= N - 1) begin
            e = '0;
            for (int j = 0; j < N; j++) begin
                src = mr - (N - 1 - j);
                e = (e << DW) | CWID'(src < 0 ? img[0][mc] : img[src][mc]);
            end
            last = (mr == IH - 1) && (mc == IW - 1);
            exp_q.push_back({last, e});
        end
        acc_cnt++;
        mc++;
        if (mc == IW) begin
            mc = 0;
            mr++;
            if (mr == IH) mr = 0;
        end
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; inputs stay stable until the next posedge+1.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pix(input int i);
        return DW'((i / IW) * 16 + (i % IW));
    endfunction

    // One full frame of row*16+col with directed spot checks.
    task automatic pattern_frame();
        for (int i = 0; i < IW * IH; i++) begin
            cyc(1'b1, pix(i), 1'b1);
`ifdef MEDIAN_LINE_BUF_TOP_REPLICATE_EN
            if (i == 0) begin
                check("rep_first_valid", out_valid, 1);
                check("rep_first_data", out_data, 24'h000000);
            end
            if (i == 5) check("rep_r1c1_data", out_data, 24'h010111);
            if (i == 9) check("rep_r2c1_data", out_data, 24'h011121);
`else
            if (i == 7) check("fill_no_output", out_valid, 0);
            if (i == 8) begin
                check("first_col_valid", out_valid, 1);
                check("first_col_data", out_data, 24'h001020);
            end
            if (i == 11) check("row2_last_col", out_data, 24'h031323);
`endif
            if (i == 15) begin
                check("frame_last_data", out_data, 24'h132333);
                check("frame_last_flag", out_last, 1);
            end
        end
    endtask

    // ---------------- stimulus + monitor ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        fork
            // Monitor: pops expectations whenever the DUT hands off a
            // column, and feeds accepted pixels to the model.
            forever begin
                logic [CWID:0] e;
                @(negedge clk);
                if (!rst_n) begin
                    prev_stall = 1'b0;
                    out_cnt    = 0;
                end else begin
                    if (prev_stall) begin
                        check("stall_hold_valid", out_valid, 1);
                        check("stall_hold_data", out_data, prev_data);
                        check("stall_hold_last", out_last, prev_last);
                    end
                    if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_output", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("col_data", out_data, e[CWID-1:0]);
                            check("col_last", out_last, e[CWID]);
                        end
                        out_cnt++;
                        if (out_last) begin
                            seen_lasts++;
                            check("outputs_per_frame", out_cnt, FRAME_OUTS);
                            out_cnt = 0;
                        end
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_data  = out_data;
                    prev_last  = out_last;
                    if (in_valid && in_ready) model_accept(in_data);
                end
            end

            begin
                int target;
                int cycles;
                // Reset state
                repeat (3) @(posedge clk);
                #1;
                check("rst_out_valid", out_valid, 0);
                check("rst_out_data", out_data, 0);
                check("rst_out_last", out_last, 0);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                check("rst_in_ready", in_ready, 1);

                // Fill, run and last-pixel behaviour on a continuous stream
                pattern_frame();

                // Next frame: fill rows quiet again, then backpressure
                for (int i = 0; i < 8; i++) cyc(1'b1, pix(i), 1'b1);
`ifndef MEDIAN_LINE_BUF_TOP_REPLICATE_EN
                check("frame2_fill_quiet", out_valid, 0);
`endif
                cyc(1'b1, pix(8), 1'b1);
                for (int s = 0; s < 3; s++) begin
                    cyc(1'b1, pix(9), 1'b0);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_out_valid", out_valid, 1);
                    check("bp_out_data", out_data, 24'h001020);
                end
                for (int i = 9; i < IW * IH; i++) cyc(1'b1, pix(i), 1'b1);

                // Reset in the middle of a frame
                for (int i = 0; i < 6; i++) cyc(1'b1, pix(i), 1'b1);
                rst_n    = 1'b0;
                in_valid = 1'b0;
                exp_q.delete();
                mr = 0;
                mc = 0;
                #1;
                check("midrst_out_valid", out_valid, 0);
                check("midrst_out_data", out_data, 0);
                check("midrst_out_last", out_last, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                pattern_frame();

                // Random valid/ready over three frames
                target = acc_cnt + 3 * IW * IH;
                cycles = 0;
                while (acc_cnt < target && cycles < 5000) begin
                    cyc(1'($urandom_range(0, 99) < 70), DW'($urandom), 1'($urandom_range(0, 99) < 65));
                    cycles++;
                end
                check("random_within_budget", acc_cnt, target);

                // Drain
                repeat (6) cyc(1'b0, '0, 1'b1);
                check("drain_queue_empty", exp_q.size(), 0);
                check("frames_with_last", seen_lasts, 6);
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/median_line_buffer.md
# median_line_buffer

Streaming window front-end for the median filter. Accepts a raster-order pixel stream and buffers N-1 image lines. Emits, for each accepted pixel, the vertical column of N vertically aligned pixels ending at that pixel, packed in the layout the N-input sorting stages consume. Sits directly upstream of the column sorter in the NxN median datapath.

## Interface
- N, 5: window height (pixels per output column), ≥2
- DATA_WIDTH, 8: bits per pixel
- IMG_WIDTH, 640: pixels per line, ≥2
- IMG_HEIGHT, 480: lines per frame, ≥N
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  input pixel valid
- in_data  in  DATA_WIDTH  input pixel, raster order
- in_ready  out  1  block accepts pixel this cycle
- out_valid  out  1  output column valid
- out_data  out  N*DATA_WIDTH  column; element j at bits [(N-j)*DATA_WIDTH-1 -: DATA_WIDTH]; j=0 oldest row, j=N-1 current pixel
- out_ready  in  1  downstream accepts column
- out_last  out  1  qualifies out_data as the column of the frame's final pixel

## Operation
- Accept: in_valid && in_ready. Only accepted pixels advance counters or buffers.
- Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1; col wraps to 0 and row increments at end of line. After (IMG_HEIGHT-1, IMG_WIDTH-1), both return to 0 and the next pixel starts a new frame.
- Line buffers: N-1 delay lines of IMG_WIDTH entries. On accept at column c, line k outputs its stored value for column c, line 0 stores in_data, and line k+1 stores line k's old value. Line buffer contents are not reset.
- Column: {line N-2 [c], …, line 0 [c], in_data}, with j=0 taken from line N-2.
- FSM states:
  - FILL (row < N-1): accepted pixels produce no output. Transition to RUN on accepting the last pixel of row N-2.
  - RUN: every accepted pixel loads the output register. Transition to FILL on accepting the frame's last pixel.
- out_last: set with the column of pixel (IMG_HEIGHT-1, IMG_WIDTH-1); otherwise 0.
- Reset (any time, including mid-frame): counters 0, state FILL, out_valid 0, out_data 0, out_last 0. in_ready is 1 from the first cycle after reset release. Any partially received frame is discarded; the next accepted pixel is row 0, col 0.

## Timing
- Latency: column visible on out_data/out_valid one cycle after the accepting edge.
- Output register is a single stage. in_ready = !out_valid || out_ready, combinational.
- out_data and out_last are held stable while out_valid && !out_ready.
- out_valid clears after a handshake unless a new column loads in the same cycle.
- Throughput: one pixel per cycle with out_ready held 1, including across line and frame boundaries.
- in_valid may drop at any cycle. Gaps do not corrupt alignment.

## Configuration
- MEDIAN_LINE_BUF_TOP_REPLICATE_EN
  - Undefined: rows 0..N-2 produce no output, giving (IMG_HEIGHT-N+1)*IMG_WIDTH columns per frame.
  - Defined: FILL also emits columns, so every pixel produces a column (IMG_HEIGHT*IMG_WIDTH per frame). In row r < N-1, element j with source row r-(N-1-j) < 0 is replaced by the row-0 pixel of the same column. Stale buffer data is never emitted. out_last is unchanged.

## Structure
- Shared package median_filter_pkg: FSM state enum (FILL, RUN), width helper function for the counters, and a pack function for the column layout shared with the sorter stages.
- One sub-module: median_line_delay, a single IMG_WIDTH-deep, DATA_WIDTH-wide read-before-write delay line indexed by col. It is instantiated N-1 times, chained.

## Test plan
All scenarios use N=3, DATA_WIDTH=8, IMG_WIDTH=4, IMG_HEIGHT=4, pixel = row*16+col, unless stated otherwise.

- Fill: stream 8 pixels → no out_valid. Accept 0x20 → next cycle out_valid=1, out_data={0x00,0x10,0x20}. Accept 0x23 → {0x03,0x13,0x23}.
- Backpressure: out_ready=0 for 3 cycles while out_valid → in_ready=0, out_data unchanged. out_ready=1 → streaming resumes with no lost or duplicated column.
- Continuous stream, in_valid=out_ready=1 → 8 outputs per frame, one per cycle. out_last=1 only with {0x13,0x23,0x33}. The next frame's first 8 pixels produce nothing.
- Reset mid-frame: rst_n low for 1 cycle after 6 pixels → outputs 0 immediately. After release, the first out_valid follows the 9th newly accepted pixel, with {0x00,0x10,0x20}.
- Random in_valid/out_ready over 3 frames → output sequence equals the reference model, with out_last exactly once per frame.
- Macro defined: 0x00 → {0x00,0x00,0x00}. 0x11 → {0x01,0x01,0x11}. 0x21 → {0x01,0x11,0x21}. 16 outputs per frame.
